// File: rtl/board_input_conditioner_if.sv
// rtl/board_input_conditioner_if.sv - raw board pins in, conditioned key/switch levels and pulses out
interface board_input_conditioner_if #(
  parameter int N_KEYS = 4,
  parameter int N_SW   = 10
);
  logic [N_KEYS-1:0] KEY;
  logic [N_SW-1:0]   SW;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_SW-1:0]   sw_level;
  logic [N_SW-1:0]   sw_change;

  modport master (
    output KEY, SW,
    input  key_down, key_press, key_release, sw_level, sw_change
  );

  modport slave (
    input  KEY, SW,
    output key_down, key_press, key_release, sw_level, sw_change
  );
endinterface

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - 2-flop sync plus per-bit debounce for KEY and SW pins
module board_input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                      CLOCK50,
  input  logic                      reset,
  board_input_conditioner_if.slave  bus
);

  // Keys occupy the low bits, switches the high bits; every bit is an identical channel.
  localparam int N  = N_KEYS + N_SW;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Keys rest high (released, active-low pins), switches rest low.
  localparam logic [N-1:0]  RST_VAL = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

  logic [N-1:0]      raw;
  logic [N-1:0]      sync1;
  logic [N-1:0]      sync2;
  logic [N-1:0]      stable;
  logic [N-1:0]      accept;
  logic [CW-1:0]     cnt [N];

  logic [N_KEYS-1:0] key_down_r;
  logic [N_KEYS-1:0] key_press_r;
  logic [N_KEYS-1:0] key_release_r;
  logic [N_SW-1:0]   sw_change_r;

  assign raw = {bus.SW, bus.KEY};

  // Two-flop synchronizer for the asynchronous pin levels.
  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A channel accepts its new level on the edge its mismatch run reaches the threshold.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Debounce counters: any return to the stable level restarts the count.
  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      stable <= RST_VAL;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered key level and one-cycle edge pulses, updated together with stable.
  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      key_down_r    <= '0;
      key_press_r   <= '0;
      key_release_r <= '0;
      sw_change_r   <= '0;
    end else begin
      key_down_r    <= (key_down_r & ~accept[N_KEYS-1:0]) |
                       (accept[N_KEYS-1:0] & ~sync2[N_KEYS-1:0]);
      key_press_r   <= accept[N_KEYS-1:0] & ~sync2[N_KEYS-1:0];
      key_release_r <= accept[N_KEYS-1:0] & sync2[N_KEYS-1:0];
      sw_change_r   <= accept[N-1:N_KEYS];
    end
  end

  assign bus.key_down    = key_down_r;
  assign bus.key_press   = key_press_r;
  assign bus.key_release = key_release_r;
  assign bus.sw_level    = stable[N-1:N_KEYS];
  assign bus.sw_change   = sw_change_r;

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - self-checking bench for board_input_conditioner
module tb_board_input_conditioner;

  localparam int NK = 4;
  localparam int NS = 10;
  localparam int D  = 4;
  localparam int N  = NK + NS;
  localparam logic [N-1:0] REST = {{NS{1'b0}}, {NK{1'b1}}};

  logic CLOCK50 = 1'b0;
  logic reset   = 1'b1;

  board_input_conditioner_if #(.N_KEYS(NK), .N_SW(NS)) bus ();

  board_input_conditioner #(
    .N_KEYS(NK),
    .N_SW(NS),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK50(CLOCK50),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 CLOCK50 = ~CLOCK50;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: a level is accepted once the raw samples taken 2..D+1 edges ago all differ
  // from the accepted level (D consecutive samples, then two edges of sync/update latency).
  logic [N-1:0]  hist [1:D+1];
  logic [N-1:0]  m_stable;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_rel;
  logic [NS-1:0] m_chg;

  function automatic logic [N-1:0] accepts();
    logic [N-1:0] a;
    a = '1;
    for (int k = 2; k <= D + 1; k++) a = a & (hist[k] ^ m_stable);
    return a;
  endfunction

  always @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= D + 1; k++) hist[k] <= REST;
      m_stable <= REST;
      m_press  <= '0;
      m_rel    <= '0;
      m_chg    <= '0;
    end else begin
      m_press  <= accepts() & m_stable[NK-1:0];
      m_rel    <= accepts() & ~m_stable[NK-1:0];
      m_chg    <= accepts() >> NK;
      m_stable <= m_stable ^ accepts();
      for (int k = D + 1; k >= 2; k--) hist[k] <= hist[k-1];
      hist[1] <= {bus.SW, bus.KEY};
    end
  end

  task automatic expect_out(input string name,
                            input logic [NK-1:0] kd, input logic [NK-1:0] kp,
                            input logic [NK-1:0] kr, input logic [NS-1:0] sl,
                            input logic [NS-1:0] sc);
    tests++;
    if (bus.key_down !== kd) begin
      fails++;
      $display("FAIL %s.key_down: got %h expected %h", name, bus.key_down, kd);
    end
    tests++;
    if (bus.key_press !== kp) begin
      fails++;
      $display("FAIL %s.key_press: got %h expected %h", name, bus.key_press, kp);
    end
    tests++;
    if (bus.key_release !== kr) begin
      fails++;
      $display("FAIL %s.key_release: got %h expected %h", name, bus.key_release, kr);
    end
    tests++;
    if (bus.sw_level !== sl) begin
      fails++;
      $display("FAIL %s.sw_level: got %h expected %h", name, bus.sw_level, sl);
    end
    tests++;
    if (bus.sw_change !== sc) begin
      fails++;
      $display("FAIL %s.sw_change: got %h expected %h", name, bus.sw_change, sc);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK50) begin
    if (chk_en) begin
      expect_out("model", ~m_stable[NK-1:0], m_press, m_rel, m_stable[N-1:NK], m_chg);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK50);
  endtask

  initial begin
    bus.KEY = 4'hF;
    bus.SW  = 10'h000;
    reset   = 1'b1;
    @(negedge CLOCK50);
    chk_en = 1'b1;
    tick(2);
    expect_out("reset", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    reset = 1'b0;
    tick(20);
    expect_out("idle", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);

    bus.KEY = 4'hE;
    tick(5);
    expect_out("press_e4", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    tick(1);
    expect_out("press_e5", 4'h1, 4'h1, 4'h0, 10'h000, 10'h000);
    tick(1);
    expect_out("press_hold", 4'h1, 4'h0, 4'h0, 10'h000, 10'h000);
    tick(3);
    bus.KEY = 4'hF;
    tick(6);
    expect_out("release_e5", 4'h0, 4'h0, 4'h1, 10'h000, 10'h000);
    tick(1);
    expect_out("release_after", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);

    tick(3);
    bus.KEY = 4'hD;
    tick(2);
    bus.KEY = 4'hF;
    tick(1);
    bus.KEY = 4'hD;
    tick(5);
    expect_out("bounce_e4", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    tick(1);
    expect_out("bounce_e5", 4'h2, 4'h2, 4'h0, 10'h000, 10'h000);
    tick(2);
    bus.KEY = 4'hF;
    tick(8);
    expect_out("bounce_released", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);

    bus.SW = 10'h2A5;
    tick(5);
    expect_out("sw_e4", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    tick(1);
    expect_out("sw_e5", 4'h0, 4'h0, 4'h0, 10'h2A5, 10'h2A5);
    tick(1);
    expect_out("sw_after", 4'h0, 4'h0, 4'h0, 10'h2A5, 10'h000);

    bus.KEY = 4'hB;
    tick(8);
    expect_out("k2_down", 4'h4, 4'h0, 4'h0, 10'h2A5, 10'h000);
    bus.KEY = 4'h7;
    tick(5);
    expect_out("simul_e4", 4'h4, 4'h0, 4'h0, 10'h2A5, 10'h000);
    tick(1);
    expect_out("simul_e5", 4'h8, 4'h8, 4'h4, 10'h2A5, 10'h000);
    bus.KEY = 4'hF;
    tick(8);
    expect_out("all_up", 4'h0, 4'h0, 4'h0, 10'h2A5, 10'h000);

    bus.KEY = 4'hE;
    tick(3);
    @(posedge CLOCK50);
    #1 reset = 1'b1;
    tick(1);
    expect_out("in_reset", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    tick(2);
    expect_out("in_reset_hold", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    reset = 1'b0;
    tick(5);
    expect_out("post_rst_e4", 4'h0, 4'h0, 4'h0, 10'h000, 10'h000);
    tick(1);
    expect_out("post_rst_e5", 4'h1, 4'h1, 4'h0, 10'h2A5, 10'h2A5);
    tick(1);
    expect_out("post_rst_after", 4'h1, 4'h0, 4'h0, 10'h2A5, 10'h000);

    tick(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
